uart_rx_ctrl: RTL

UART receive controller: sequences the oversampling counters, bit counter and shift register of the receive datapath, and delivers each received byte through a valid/ready holding register. It takes the raw serial line from the pad and hands bytes to the host-side consumer. It also flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_datapath.sv | 85 ++++++++
 rtl/uart_rx_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM states, counter commands, control points.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // Per-counter command issued by the FSM each cycle.
    typedef enum logic [1:0] {NO, INC, CLR} ctrl_t;

    typedef struct packed {
        ctrl_t clk_ctrl;
        ctrl_t sample_ctrl;
        ctrl_t bit_ctrl;
        logic  shift_en;
        logic  load_hold;
    } rx_cpts_t;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: oversampling/bit counters, shift register and byte holding register.
// Latency: every command takes effect on the next clock edge; status points are combinational.
// Backpressure: none here; the controller decides when load_hold may fire.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   i_cpts           counter/shift/load commands from the controller FSM
//   i_rx_sync        synchronized serial line
//   o_tick           clock counter at its last value (one oversample tick)
//   o_mid_start      tick at the middle of the start bit
//   o_mid_bit        tick at the middle of a data/stop bit
//   o_last_bit       bit counter points at the final data bit
//   o_rx_data        holding register contents
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 27,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  rx_cpts_t             i_cpts,
    input  logic                 i_rx_sync,
    output logic                 o_tick,
    output logic                 o_mid_start,
    output logic                 o_mid_bit,
    output logic                 o_last_bit,
    output logic [DATA_BITS-1:0] o_rx_data
);

    localparam int CW = cnt_width(CLKS_PER_SAMPLE);
    localparam int SW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS + 1);

    logic [CW-1:0]        r_clk_count;
    logic [SW-1:0]        r_sample_count;
    logic [BW-1:0]        r_bit_count;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;

    assign o_tick      = (r_clk_count == CW'(CLKS_PER_SAMPLE - 1));
    assign o_mid_start = o_tick && (r_sample_count == SW'(OVERSAMPLE / 2 - 1));
    // Sample counter is restarted at mid start bit, so its wrap point lands mid-bit.
    assign o_mid_bit   = o_tick && (r_sample_count == SW'(OVERSAMPLE - 1));
    assign o_last_bit  = (r_bit_count == BW'(DATA_BITS - 1));
    assign o_rx_data   = r_rx_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_count    <= '0;
            r_sample_count <= '0;
            r_bit_count    <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
        end else begin
            case (i_cpts.clk_ctrl)
                CLR:     r_clk_count <= '0;
                INC:     r_clk_count <= o_tick ? '0 : r_clk_count + 1'b1;
                default: ;
            endcase

            case (i_cpts.sample_ctrl)
                CLR:     r_sample_count <= '0;
                INC:     r_sample_count <= (r_sample_count == SW'(OVERSAMPLE - 1)) ?
                                           '0 : r_sample_count + 1'b1;
                default: ;
            endcase

            case (i_cpts.bit_ctrl)
                CLR:     r_bit_count <= '0;
                INC:     r_bit_count <= r_bit_count + 1'b1;
                default: ;
            endcase

            // LSB arrives first, so shifting right leaves it at bit 0 after the last bit.
            if (i_cpts.shift_en)
                r_shift <= {i_rx_sync, r_shift[DATA_BITS-1:1]};

            if (i_cpts.load_hold)
                r_rx_data <= r_shift;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizer, frame FSM, valid/ready holding handshake, error pulses.
// Latency: byte visible 1 cycle after the mid-stop-bit sample (C*(N/2+N*(DATA_BITS+1))+1 after START).
// Backpressure: one-entry holding register; a byte completing while it is full and not accepted is dropped (overrun_err).
//
// Ports:
//   clock, reset_n   sole clock, asynchronous active-low reset
//   rx_serial        raw asynchronous serial line, idle high
//   rx_data          received byte, valid while rx_valid
//   rx_valid         holding register full
//   rx_ready         consumer accepts when rx_valid && rx_ready
//   framing_err      one-cycle pulse: stop bit sampled low
//   overrun_err      one-cycle pulse: completed byte dropped
//   busy             FSM not in IDLE
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 27,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    generate
        if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
            $error("uart_rx_ctrl: OVERSAMPLE must be even and >= 4");
        end
        if (CLKS_PER_SAMPLE < 1) begin : g_bad_clks
            $error("uart_rx_ctrl: CLKS_PER_SAMPLE must be >= 1");
        end
    endgenerate

    rx_state_t r_state;
    rx_state_t w_next_state;
    rx_cpts_t  w_cpts;

    logic r_sync1;
    logic r_sync2;
    logic w_rx_sync;
    logic w_tick;
    logic w_mid_start;
    logic w_mid_bit;
    logic w_last_bit;
    logic w_stop_done;

    // Stop-bit outcome is registered so all handshake/error effects land one cycle later.
    logic r_stop_done;
    logic r_stop_bit;
    logic r_rx_valid;
    logic r_framing_err;
    logic r_overrun_err;

    assign w_rx_sync = r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    uart_rx_datapath #(
        .CLKS_PER_SAMPLE (CLKS_PER_SAMPLE),
        .OVERSAMPLE      (OVERSAMPLE),
        .DATA_BITS       (DATA_BITS)
    ) u_datapath (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_cpts      (w_cpts),
        .i_rx_sync   (w_rx_sync),
        .o_tick      (w_tick),
        .o_mid_start (w_mid_start),
        .o_mid_bit   (w_mid_bit),
        .o_last_bit  (w_last_bit),
        .o_rx_data   (rx_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_cpts       = '{clk_ctrl: INC, sample_ctrl: NO, bit_ctrl: NO,
                         shift_en: 1'b0, load_hold: 1'b0};
        w_stop_done  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cpts.clk_ctrl    = CLR;
                w_cpts.sample_ctrl = CLR;
                w_cpts.bit_ctrl    = CLR;
                if (!w_rx_sync)
                    w_next_state = START;
            end
            START: begin
                if (w_tick)
                    w_cpts.sample_ctrl = INC;
                if (w_mid_start)
                    w_next_state = w_rx_sync ? IDLE : DATA;
            end
            DATA: begin
                if (w_tick)
                    w_cpts.sample_ctrl = INC;
                if (w_mid_bit) begin
                    w_cpts.shift_en = 1'b1;
                    w_cpts.bit_ctrl = INC;
                    if (w_last_bit)
                        w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_tick)
                    w_cpts.sample_ctrl = INC;
                if (w_mid_bit) begin
                    w_next_state = IDLE;
                    w_stop_done  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // Every state change restarts the bit timing from zero.
        if (w_next_state != r_state) begin
            w_cpts.clk_ctrl    = CLR;
            w_cpts.sample_ctrl = CLR;
            w_cpts.bit_ctrl    = CLR;
        end

        // A good byte loads if the register is empty or being drained this very cycle.
        w_cpts.load_hold = r_stop_done && r_stop_bit && (!r_rx_valid || rx_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stop_done   <= 1'b0;
            r_stop_bit    <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_stop_done   <= w_stop_done;
            r_stop_bit    <= w_rx_sync;
            r_framing_err <= r_stop_done && !r_stop_bit;
            r_overrun_err <= r_stop_done && r_stop_bit && r_rx_valid && !rx_ready;
            if (w_cpts.load_hold)
                r_rx_valid <= 1'b1;
            else if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;
        end
    end

    assign rx_valid    = r_rx_valid;
    assign framing_err = r_framing_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != IDLE);

endmodule
